fifo_write_arbiter: RTL and testbench

//  Shares the single FIFO write port between NREQ producers with round-robin, burst-capable arbitration.

---
 rtl/fifo_write_arbiter_pkg.sv | 14 +
 rtl/fifo_write_arbiter_if.sv | 29 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state and index-width helper.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-facing bus of the write arbiter; master is the arbiter side.
interface fifo_write_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16
) ();
   import fifo_arb_pkg::*;

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] reqData;
   logic              fifoFull;
   logic [NREQ-1:0]   gnt;
   logic              wrEn;
   logic [W-1:0]      wrData;
   logic [IW-1:0]     owner;
   logic              burstActive;

   modport master (
      input  req, reqData, fifoFull,
      output gnt, wrEn, wrData, owner, burstActive
   );

   modport slave (
      output req, reqData, fifoFull,
      input  gnt, wrEn, wrData, owner, burstActive
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_ptr_i, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW  = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [IW-1:0]   index_o,
   output logic            any_o
);

   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   // One extra bit holds last_ptr+k before the modulo fold.
   logic [IW:0] sum;

   always_comb begin
      onehot_o = '0;
      index_o  = '0;
      any_o    = 1'b0;
      sum      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         sum = {1'b0, last_ptr_i} + (IW+1)'(k);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         if (!any_o && req_i[sum[IW-1:0]]) begin
            any_o                 = 1'b1;
            index_o               = sum[IW-1:0];
            onehot_o[sum[IW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-capable arbiter sharing one FIFO write port among NREQ producers.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int W         = 16,
   parameter int MAX_BURST = 8
) (
   input  logic                 wrClk,
   input  logic                 wrRst,
   fifo_write_arbiter_if.master bus
);

   localparam int            IW      = idx_w(NREQ);
   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   arb_state_e    st_q, st_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [CW-1:0] beat_q, beat_d;
   logic [IW-1:0] last_q, last_d;

   logic [NREQ-1:0] pick_onehot;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic [CW-1:0]   beat_inc;
   logic [NREQ-1:0] gnt;
   logic [W-1:0]    data_masked [NREQ];

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i      (bus.req),
      .last_ptr_i (last_q),
      .onehot_o   (pick_onehot),
      .index_o    (pick_idx),
      .any_o      (pick_any)
   );

   always_ff @(posedge wrClk or posedge wrRst) begin
      if (wrRst) begin
         st_q    <= IDLE;
         owner_q <= '0;
         beat_q  <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         st_q    <= st_d;
         owner_q <= owner_d;
         beat_q  <= beat_d;
         last_q  <= last_d;
      end
   end

   assign beat_inc = beat_q + CW'(1);

   always_comb begin
      st_d    = st_q;
      owner_d = owner_q;
      beat_d  = beat_q;
      last_d  = last_q;
      case (st_q)
         IDLE: begin
            if (!bus.fifoFull && pick_any) begin
               owner_d = pick_idx;
               beat_d  = CW'(1);
               if (MAX_BURST == 1) begin
                  last_d = pick_idx;
               end else begin
                  st_d = BURST;
               end
            end
         end
         BURST: begin
            // A full FIFO freezes the tenure, even if the owner has dropped its request.
            if (!bus.fifoFull) begin
               if (bus.req[owner_q]) begin
                  beat_d = beat_inc;
                  if (beat_inc == MAX_CNT) begin
                     st_d   = IDLE;
                     last_d = owner_q;
                  end
               end else begin
                  st_d   = IDLE;
                  last_d = owner_q;
               end
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_comb begin
      gnt = '0;
      if (!wrRst && !bus.fifoFull) begin
         if (st_q == IDLE) begin
            gnt = pick_onehot;
         end else if (bus.req[owner_q]) begin
            gnt[owner_q] = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mux
         assign data_masked[gi] = {W{gnt[gi]}} & bus.reqData[gi*W +: W];
      end
   endgenerate

   always_comb begin
      bus.wrData = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.wrData = bus.wrData | data_masked[i];
      end
   end

   assign bus.gnt         = gnt;
   assign bus.wrEn        = |gnt;
   assign bus.owner       = owner_q;
   assign bus.burstActive = (st_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST 1 and 8) driven by identical stimulus.
module tb_fifo_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic        full = 1'b0;
   logic [63:0] rdata = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NREQ(4), .W(16)) bus_a ();
   fifo_write_arbiter_if #(.NREQ(4), .W(16)) bus_b ();

   assign bus_a.req      = req;
   assign bus_a.reqData  = rdata;
   assign bus_a.fifoFull = full;
   assign bus_b.req      = req;
   assign bus_b.reqData  = rdata;
   assign bus_b.fifoFull = full;

   fifo_write_arbiter #(.NREQ(4), .W(16), .MAX_BURST(1)) dut_a (
      .wrClk (clk),
      .wrRst (rst),
      .bus   (bus_a.master)
   );

   fifo_write_arbiter #(.NREQ(4), .W(16), .MAX_BURST(8)) dut_b (
      .wrClk (clk),
      .wrRst (rst),
      .bus   (bus_b.master)
   );

   typedef struct {
      logic [3:0]  gnt;
      logic [15:0] data;
      logic        busy;
      logic [1:0]  owner;
      logic        chk_owner;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   // Reference arbiter state per DUT: tenure flag, owner, beats used, last winner.
   int m_last[2]  = '{3, 3};
   int m_owner[2] = '{0, 0};
   int m_beats[2] = '{0, 0};
   bit m_busy[2]  = '{0, 0};
   int mb[2]      = '{1, 8};

   function automatic exp_t model_step(input int d, input logic r,
                                       input logic [3:0] rq, input logic f);
      exp_t e;
      int   w;
      e.gnt       = '0;
      e.data      = '0;
      e.busy      = m_busy[d];
      e.owner     = 2'(m_owner[d]);
      e.chk_owner = m_busy[d];
      w = -1;
      if (r) begin
         m_busy[d]  = 0;
         m_owner[d] = 0;
         m_beats[d] = 0;
         m_last[d]  = 3;
         e.busy      = 1'b0;
         e.owner     = 2'd0;
         e.chk_owner = 1'b1;
      end else if (!m_busy[d]) begin
         if (!f) begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_last[d] + k) % 4;
               if (w < 0 && rq[c]) w = c;
            end
         end
         if (w >= 0) begin
            m_owner[d] = w;
            m_beats[d] = 1;
            if (mb[d] == 1) m_last[d] = w;
            else            m_busy[d] = 1;
         end
      end else if (!f) begin
         if (rq[m_owner[d]]) begin
            w = m_owner[d];
            m_beats[d] = m_beats[d] + 1;
            if (m_beats[d] == mb[d]) begin
               m_busy[d] = 0;
               m_last[d] = m_owner[d];
            end
         end else begin
            m_busy[d] = 0;
            m_last[d] = m_owner[d];
         end
      end
      if (w >= 0) begin
         e.gnt  = 4'b0001 << w;
         e.data = rdata[w*16 +: 16];
      end
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [3:0] g, input logic we,
                      input logic [15:0] wd, input logic ba, input logic [1:0] ow,
                      input logic fl);
      check({tag, ".gnt"},         32'(g),  32'(e.gnt));
      check({tag, ".wrEn"},        32'(we), 32'(|e.gnt));
      check({tag, ".wrData"},      32'(wd), 32'(e.data));
      check({tag, ".burstActive"}, 32'(ba), 32'(e.busy));
      if (e.chk_owner) check({tag, ".owner"}, 32'(ow), 32'(e.owner));
      check({tag, ".wrEn_while_full"}, 32'(we & fl), 32'd0);
      check({tag, ".gnt_onehot0"},     32'($onehot0(g)), 32'd1);
      if (we) $display("txn %s t=%0t gnt=%b data=%h burst=%b", tag, $time, g, wd, ba);
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic f);
      @(posedge clk);
      #1;
      rst  = r;
      req  = rq;
      full = f;
      q_a.push_back(model_step(0, r, rq, f));
      q_b.push_back(model_step(1, r, rq, f));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("a", e, bus_a.gnt, bus_a.wrEn, bus_a.wrData, bus_a.burstActive, bus_a.owner, full);
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("b", e, bus_b.gnt, bus_b.wrEn, bus_b.wrData, bus_b.burstActive, bus_b.owner, full);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      // Reset held with all requesters active, then release into fairness.
      repeat (2) step(1'b1, 4'b1111, 1'b0);
      repeat (8) step(1'b0, 4'b1111, 1'b0);
      // Single requester: burst cap and restart.
      step(1'b1, 4'b0000, 1'b0);
      repeat (12) step(1'b0, 4'b0100, 1'b0);
      // Backpressure in the middle of a tenure.
      step(1'b1, 4'b0000, 1'b0);
      repeat (3) step(1'b0, 4'b0001, 1'b0);
      repeat (5) step(1'b0, 4'b0001, 1'b1);
      repeat (6) step(1'b0, 4'b0001, 1'b0);
      // Owner drops early while another requester waits.
      step(1'b1, 4'b0000, 1'b0);
      repeat (2) step(1'b0, 4'b1010, 1'b0);
      repeat (3) step(1'b0, 4'b1000, 1'b0);
      // Random traffic with occasional resets.
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
      end
      step(1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
      #1;
      check("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
